sw_ld_conditioner: RTL

SW_LD_CONDITIONER -- requirements
Module: sw_ld_conditioner

---
 rtl/sw_ld_pkg.sv | 24 ++
 rtl/debounce_bit.sv | 55 +++++
 rtl/sw_ld_conditioner.sv | 82 ++++++++
 3 files changed

// File: rtl/sw_ld_pkg.sv
// Shared types and defaults for the switch/load conditioner.
package sw_ld_pkg;

   // Default synchronizer depth and debounce interval.
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_DB_CYCLES   = 1000000;

   // Number of slide switches feeding the counter load data.
   localparam int unsigned NUM_SW = 4;

   // Press FSM state encoding.
   localparam int unsigned STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t FIRE = 2'd1;
   localparam state_t HELD = 2'd2;

   // Debounce counter width: must hold the value DB_CYCLES itself.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One raw input: synchronizer chain, stability counter and debounced flop.
module debounce_bit
   import sw_ld_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_db
);

   localparam int unsigned CNT_W = cnt_width(DB_CYCLES);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_db;

   logic                   w_sync;
   logic                   w_differ;
   logic                   w_expire;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_differ = w_sync ^ r_db;
   // Counter has seen DB_CYCLES consecutive mismatching cycles.
   assign w_expire = (r_cnt == CNT_W'(DB_CYCLES));

   // Metastability chain: raw bit shifts in at the LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   // Count stable mismatch cycles; accept the new level once the count expires.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_db  <= 1'b0;
      end else if (!w_differ) begin
         r_cnt <= '0;
      end else if (w_expire) begin
         r_db  <= w_sync;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/sw_ld_conditioner.sv
// Conditions the load pushbutton and slide switches for a loadable counter:
// debounces every raw input and turns each debounced press into one ld strobe.
module sw_ld_conditioner
   import sw_ld_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_raw,
   input  logic [NUM_SW-1:0] sw_raw,
   output logic              ld,
   output logic [NUM_SW-1:0] sw,
   output logic              btn_db
);

   logic              w_btn_db;
   logic [NUM_SW-1:0] w_sw_db;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_ld;

   // Load button conditioning.
   debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_btn_db (
      .clk   (clk),
      .rst   (rst),
      .i_raw (btn_raw),
      .o_db  (w_btn_db)
   );

   // Per-switch conditioning.
   for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
      debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_sw_db (
         .clk   (clk),
         .rst   (rst),
         .i_raw (sw_raw[gi]),
         .o_db  (w_sw_db[gi])
      );
   end

   // Press FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Press FSM next state: fire once, then wait for release before rearming.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_btn_db) w_state_nxt = FIRE;
         FIRE:    w_state_nxt = HELD;
         HELD:    if (!w_btn_db) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ld is registered from the next state so it is high exactly while in FIRE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ld <= 1'b0;
      end else begin
         r_ld <= (w_state_nxt == FIRE);
      end
   end

   assign ld     = r_ld;
   assign sw     = w_sw_db;
   assign btn_db = w_btn_db;

endmodule
